// File: rtl/multicycle_proc_param.sv
// Parametrised multicycle processor: fetches an instruction in T0, then executes it
// over 1-3 steps on a shared internal bus using a register file plus A/G registers.
module multicycle_proc_param #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    localparam int REG_BITS = $clog2(NUM_REGS),
    localparam int IR_W     = 3 + 2 * REG_BITS
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic              done,
    output logic              busy,
    output logic              z_flag,
    output logic [DATA_W-1:0] bus_out
);

    if (NUM_REGS < 2 || NUM_REGS > 16 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
        $fatal(1, "multicycle_proc_param: NUM_REGS must be a power of two in 2..16");
    end
    if (IR_W > DATA_W) begin : g_bad_ir_w
        $fatal(1, "multicycle_proc_param: instruction word does not fit in DATA_W");
    end

    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_ILL = 3'b111
    } opcode_t;

    step_t               step_q, step_d;
    logic [IR_W-1:0]     ir_q;
    logic [DATA_W-1:0]   rf_q [NUM_REGS];
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   g_q;
    logic                z_q;

    opcode_t             op;
    logic [REG_BITS-1:0] rx;
    logic [REG_BITS-1:0] ry;
    logic [DATA_W-1:0]   bus;
    logic [DATA_W-1:0]   alu_res;
    logic                done_c;
    logic                rf_we;
    logic                a_we;
    logic                g_we;

    assign op = opcode_t'(ir_q[IR_W-1 -: 3]);
    assign rx = ir_q[2*REG_BITS-1 -: REG_BITS];
    assign ry = ir_q[REG_BITS-1:0];

    // Every register-file write takes its data from the bus (Ry, din or G).
    always_comb begin
        bus    = '0;
        done_c = 1'b0;
        rf_we  = 1'b0;
        a_we   = 1'b0;
        g_we   = 1'b0;
        unique case (step_q)
            T0: ;
            T1: begin
                unique case (op)
                    OP_MV: begin
                        bus    = rf_q[ry];
                        rf_we  = 1'b1;
                        done_c = 1'b1;
                    end
                    OP_MVI: begin
                        bus    = din;
                        rf_we  = 1'b1;
                        done_c = 1'b1;
                    end
                    OP_ILL: done_c = 1'b1;
                    default: begin
                        bus  = rf_q[rx];
                        a_we = 1'b1;
                    end
                endcase
            end
            T2: begin
                bus  = rf_q[ry];
                g_we = 1'b1;
            end
            T3: begin
                bus    = g_q;
                rf_we  = 1'b1;
                done_c = 1'b1;
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_ADD:  alu_res = a_q + bus;
            OP_SUB:  alu_res = a_q - bus;
            OP_AND:  alu_res = a_q & bus;
            OP_OR:   alu_res = a_q | bus;
            OP_XOR:  alu_res = a_q ^ bus;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        step_d = step_q;
        if (step_q == T0) begin
            step_d = run ? T1 : T0;
        end else if (done_c) begin
            step_d = T0;
        end else begin
            step_d = step_t'(step_q + 2'd1);
        end
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            step_q <= T0;
            ir_q   <= '0;
            a_q    <= '0;
            g_q    <= '0;
            z_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            step_q <= step_d;
            if (step_q == T0 && run) begin
                ir_q <= din[IR_W-1:0];
            end
            if (a_we) begin
                a_q <= bus;
            end
            if (g_we) begin
                g_q <= alu_res;
                z_q <= (alu_res == '0);
            end
            if (rf_we) begin
                rf_q[rx] <= bus;
            end
        end
    end

    assign done    = done_c;
    assign busy    = (step_q != T0);
    assign z_flag  = z_q;
    assign bus_out = bus;

endmodule

// File: doc/multicycle_proc_param.md
Name: multicycle_proc_param

Overview:
- Parametrised successor of the team's 8-register multicycle processor.
- Fetches an instruction word from din when run is asserted. Executes it over 1-3 further clock steps on a shared data bus, using a register file, A (operand) register and G (result) register.
- Adds the following over the previous generation:
  - configurable data width and register count;
  - logic ops (and/or/xor);
  - a zero flag;
  - a defined handling for illegal opcodes.

Parameters:
- DATA_W, 16, width of registers, bus, din and ALU.
- NUM_REGS, 8, number of general registers; must be a power of two, 2..16.
- REG_BITS, $clog2(NUM_REGS), register-index field width (derived; do not override).
- IR_W, 3+2*REG_BITS, instruction width (derived).

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- resetn  in  1  asynchronous, active-high reset (port name kept from codebase; asserted = 1).
- run  in  1  start request, sampled only in step T0.
- din  in  DATA_W  instruction in T0 (low IR_W bits), immediate data in mvi T1.
- done  out  1  high during the final step cycle of an instruction.
- busy  out  1  high whenever step != T0.
- z_flag  out  1  set by ALU ops: 1 if result == 0.
- bus_out  out  DATA_W  current internal bus value.

Behaviour:
- IR format, MSB first: opcode[2:0] | X[REG_BITS-1:0] | Y[REG_BITS-1:0]. Upper din bits are ignored in T0.
- Opcodes:
  - 000 mv Rx<=Ry
  - 001 mvi Rx<=din
  - 010 add
  - 011 sub
  - 100 and
  - 101 or
  - 110 xor
  - 111 illegal (NOP)
- Step counter T0..T3 is 2-bit; it returns to T0 on the edge that ends a cycle with done=1.
- T0 (idle):
  - If run=1, latch IR<=din[IR_W-1:0] and go to T1.
  - Otherwise stay in T0; registers are unchanged.
  - done=0, bus=0.
- mv, T1: bus=Ry, Rx<=bus, done=1. Total 2 cycles including fetch.
- mvi, T1: bus=din, Rx<=din, done=1.
- ALU ops:
  - T1: bus=Rx, A<=bus.
  - T2: bus=Ry, G<=A op bus.
  - T3: bus=G, Rx<=G, done=1. Total 4 cycles.
- Arithmetic: add/sub are modulo 2^DATA_W; carry/borrow is discarded. sub computes A-Ry. Logic ops are bitwise.
- z_flag updates on the T2 edge of ALU ops only: z_flag <= (result==0). mv/mvi/illegal leave it unchanged.
- Illegal (111): T1 drives bus=0, writes nothing, done=1.
- X==Y is legal:
  - add R1,R1 doubles R1.
  - sub R1,R1 gives 0 and z_flag=1.
- run while busy: ignored; no queueing.
- run held high continuously: a new fetch occurs on the T0 immediately after each done.
- Only one register-write enable is active per cycle. Writes happen on the rising edge of the cycle with done=1 (mv/mvi/ALU).
- done and bus are combinational from step and IR. busy is combinational from step.
- Reset (async, any time, including mid-instruction):
  - All Rn, A, G, IR = 0; step=T0; z_flag=0.
  - done=0, busy=0, bus_out=0.
  - The in-flight instruction is aborted with no partial write.
- Elaboration check: a non-power-of-two NUM_REGS, or NUM_REGS outside 2..16, is a fatal error.

Test Plan:
- Reset then mvi R0,5 (din=0x0040 with run=1, then din=0x0005): next cycle done=1 and bus_out=5. After the edge, R0=5, busy=0.
- mvi R1,3, then add R0,R1 (IR=0x081): done asserted in 4th cycle only; bus_out=3 in T2 and 8 in T3. R0=8, z_flag=0.
- sub R1,R1 (IR=0x0C9) with R1=3: R1=0, z_flag=1. A following mv R2,R0 (IR=0x010) leaves z_flag=1 and sets R2=8.
- Illegal opcode IR=0x1C0: done=1 in T1, no register changes, bus_out=0. Pulse run during T1/T2 of an add: no extra instruction executes.
- Assert resetn (=1) during T2 of an add: all registers read 0, step=T0 immediately. After release, run resumes normally.
- DATA_W=8, NUM_REGS=4 (IR_W=7):
  - mvi R3,0xFF then add R3,R3 gives R3=0xFE (wrap).
  - xor R3,R3 gives 0 with z_flag=1.
